// File: rtl/dab_pkg.sv
// ----------------------------------------------------------------------------
// dab_pkg
// Shared definitions for the dual-active-bridge modulator and the
// gate/dead-time stage that consumes its level commands.
//   CW          : default width of period/duty/phase words and carrier counter
//   LVL_*       : signed 2-bit bridge level encodings (+1, 0, -1)
//   modState_t  : modulator FSM state encodings
// ----------------------------------------------------------------------------
package dab_pkg;

  localparam int CW = 16;

  localparam logic signed [1:0] LVL_P1 = 2'sb01;
  localparam logic signed [1:0] LVL_Z  = 2'sb00;
  localparam logic signed [1:0] LVL_N1 = 2'sb11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } modState_t;

endpackage

// File: rtl/tps_leg.sv
// ----------------------------------------------------------------------------
// tps_leg
// Combinational bridge-leg level generator. Shifts the carrier count back by
// the leg's phase lag (modulo the period) and maps the shifted count onto the
// three-level pattern: +1 for the first D counts, -1 for the first D counts of
// the second half, 0 elsewhere.
//   i_cnt   : carrier count, 0..Ps-1
//   i_ps    : carrier period (even, >= 4)
//   i_half  : Ps/2
//   i_phi   : phase lag, 0..Ps-1
//   i_duty  : pulse width per half-period, <= i_half
//   o_level : signed level command
// ----------------------------------------------------------------------------
module tps_leg
  import dab_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic [CW-1:0]     i_cnt,
  input  logic [CW-1:0]     i_ps,
  input  logic [CW-1:0]     i_half,
  input  logic [CW-1:0]     i_phi,
  input  logic [CW-1:0]     i_duty,
  output logic signed [1:0] o_level
);

  logic [CW:0] w_c2;
  logic [CW:0] w_halfPlusDuty;

  // One extra bit keeps cnt+Ps and H+D free of overflow at full-scale periods.
  always_comb begin
    w_halfPlusDuty = {1'b0, i_half} + {1'b0, i_duty};
    if (i_cnt >= i_phi) begin
      w_c2 = {1'b0, i_cnt} - {1'b0, i_phi};
    end else begin
      w_c2 = {1'b0, i_cnt} + {1'b0, i_ps} - {1'b0, i_phi};
    end

    if (w_c2 < {1'b0, i_duty}) begin
      o_level = LVL_P1;
    end else if (w_c2 < {1'b0, i_half}) begin
      o_level = LVL_Z;
    end else if (w_c2 < w_halfPlusDuty) begin
      o_level = LVL_N1;
    end else begin
      o_level = LVL_Z;
    end
  end

endmodule

// File: rtl/tps_modulator.sv
// ----------------------------------------------------------------------------
// tps_modulator
// Triple-phase-shift carrier modulator for the dual-active-bridge converter.
// Produces the primary (V1) and secondary (V2) three-level commands from a
// carrier period, per-bridge inner duty and a secondary phase lag.
//   clk, rst              : clock, asynchronous active-high reset
//   en                    : run request (level)
//   period                : carrier period in cycles (LSB ignored, min 4)
//   duty1, duty2          : per-half-period pulse widths
//   phase                 : secondary lag in cycles
//   V1, V2                : registered signed level commands
//   sync                  : marks the output cycle for carrier count 0
//   active                : output-aligned RUN/DRAIN indicator
// ----------------------------------------------------------------------------
module tps_modulator
  import dab_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [CW-1:0]        period,
  input  logic [CW-1:0]        duty1,
  input  logic [CW-1:0]        duty2,
  input  logic [CW-1:0]        phase,
  output logic signed [1:0]    V1,
  output logic signed [1:0]    V2,
  output logic                 sync,
  output logic                 active
);

  modState_t r_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_ps;
  logic [CW-1:0] r_d1;
  logic [CW-1:0] r_d2;
  logic [CW-1:0] r_phi;

  logic [CW-1:0]     w_psLoad;
  logic [CW-1:0]     w_halfLoad;
  logic [CW-1:0]     w_d1Load;
  logic [CW-1:0]     w_d2Load;
  logic [CW-1:0]     w_phiLoad;
  logic [CW:0]       w_twoPs;
  logic [CW-1:0]     w_half;
  logic [CW-1:0]     w_zero;
  logic              w_last;
  logic              w_load;
  logic signed [1:0] w_lvl1;
  logic signed [1:0] w_lvl2;

  // Clamped shadow values, derived from the period about to be loaded so
  // that duty and phase limits always match the period they run with.
  always_comb begin
    w_psLoad = period & ~CW'(1);
    if (w_psLoad < CW'(4)) begin
      w_psLoad = CW'(4);
    end
    w_halfLoad = w_psLoad >> 1;
    w_d1Load   = (duty1 < w_halfLoad) ? duty1 : w_halfLoad;
    w_d2Load   = (duty2 < w_halfLoad) ? duty2 : w_halfLoad;
    w_twoPs    = {w_psLoad, 1'b0};
    if (phase < w_psLoad) begin
      w_phiLoad = phase;
    end else if ({1'b0, phase} < w_twoPs) begin
      w_phiLoad = phase - w_psLoad;
    end else begin
      w_phiLoad = w_psLoad - CW'(1);
    end
  end

  assign w_half = r_ps >> 1;
  assign w_zero = '0;
  assign w_last = (r_cnt == (r_ps - CW'(1)));
  assign w_load = ((r_state == ST_IDLE) && en) || ((r_state == ST_RUN) && w_last);

  tps_leg #(.CW(CW)) u_legPrimary (
    .i_cnt   (r_cnt),
    .i_ps    (r_ps),
    .i_half  (w_half),
    .i_phi   (w_zero),
    .i_duty  (r_d1),
    .o_level (w_lvl1)
  );

  tps_leg #(.CW(CW)) u_legSecondary (
    .i_cnt   (r_cnt),
    .i_ps    (r_ps),
    .i_half  (w_half),
    .i_phi   (r_phi),
    .i_duty  (r_d2),
    .o_level (w_lvl2)
  );

  // Shadows only change at period boundaries, so mid-period input writes
  // never break volt-second balance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ps  <= '0;
      r_d1  <= '0;
      r_d2  <= '0;
      r_phi <= '0;
    end else if (w_load) begin
      r_ps  <= w_psLoad;
      r_d1  <= w_d1Load;
      r_d2  <= w_d2Load;
      r_phi <= w_phiLoad;
    end
  end

  // FSM, carrier counter and output registers. Outputs are computed from the
  // pre-edge state and count, giving one cycle of latency; DRAIN finishes the
  // current period so the last pulse pair is always complete.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      V1      <= LVL_Z;
      V2      <= LVL_Z;
      sync    <= 1'b0;
      active  <= 1'b0;
    end else begin
      if (r_state != ST_IDLE) begin
        V1     <= w_lvl1;
        V2     <= w_lvl2;
        sync   <= (r_cnt == '0);
        active <= 1'b1;
      end else begin
        V1     <= LVL_Z;
        V2     <= LVL_Z;
        sync   <= 1'b0;
        active <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (en) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_cnt <= w_last ? '0 : r_cnt + CW'(1);
          if (!en) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tps_modulator.sv
// ----------------------------------------------------------------------------
// tb_tps_modulator
// Directed and randomized checks of the TPS modulator against a waveform
// model built from the leg level rules: each run is started from idle with
// fixed inputs and every output cycle of whole carrier periods is compared.
// ----------------------------------------------------------------------------
module tb_tps_modulator;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [15:0]       period;
  logic [15:0]       duty1;
  logic [15:0]       duty2;
  logic [15:0]       phase;
  logic signed [1:0] V1;
  logic signed [1:0] V2;
  logic              sync;
  logic              active;

  int testCount = 0;
  int failCount = 0;

  // Effective (clamped) parameters of the period currently being checked.
  int mPs, mH, mD1, mD2, mPhi;

  always #5 clk = ~clk;

  tps_modulator #(.CW(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .period (period),
    .duty1  (duty1),
    .duty2  (duty2),
    .phase  (phase),
    .V1     (V1),
    .V2     (V2),
    .sync   (sync),
    .active (active)
  );

  // Leg level as a function of position in the period: +1, 0, -1, 0.
  function automatic logic [1:0] legLevel(input int c, input int d, input int h);
    if (c < d)     return 2'b01;
    if (c < h)     return 2'b00;
    if (c < h + d) return 2'b11;
    return 2'b00;
  endfunction

  task automatic computeModel(input int p, input int d1, input int d2, input int ph);
    mPs = (p / 2) * 2;
    if (mPs < 4) mPs = 4;
    mH   = mPs / 2;
    mD1  = (d1 < mH) ? d1 : mH;
    mD2  = (d2 < mH) ? d2 : mH;
    mPhi = (ph < 2 * mPs) ? (ph % mPs) : (mPs - 1);
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkCycle(input string tag, input int c);
    checkOutput($sformatf("%s V1 c=%0d", tag, c), V1, legLevel(c, mD1, mH));
    checkOutput($sformatf("%s V2 c=%0d", tag, c), V2,
                legLevel((c - mPhi + mPs) % mPs, mD2, mH));
    checkOutput($sformatf("%s sync c=%0d", tag, c), {1'b0, sync}, (c == 0) ? 2'b01 : 2'b00);
    checkOutput($sformatf("%s active c=%0d", tag, c), {1'b0, active}, 2'b01);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " V1"}, V1, 2'b00);
    checkOutput({tag, " V2"}, V2, 2'b00);
    checkOutput({tag, " sync"}, {1'b0, sync}, 2'b00);
    checkOutput({tag, " active"}, {1'b0, active}, 2'b00);
  endtask

  task automatic waitSync(input string tag);
    int n = 0;
    while (sync !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, " sync wait"}, {1'b0, sync}, 2'b01);
  endtask

  // Checks n whole periods starting at the current (sync) sample. When updAt
  // is non-negative, duty1 is rewritten at that count of the first period;
  // later periods are modelled from whatever inputs are applied then.
  task automatic checkPeriods(input string tag, input int n, input int updAt, input int newD1);
    for (int k = 0; k < n; k++) begin
      if (k > 0) computeModel(period, duty1, duty2, phase);
      for (int c = 0; c < mPs; c++) begin
        if (!(k == 0 && c == 0)) @(negedge clk);
        checkCycle($sformatf("%s p%0d", tag, k), c);
        if (k == 0 && c == updAt) duty1 = 16'(newD1);
      end
    end
  endtask

  // Stops any run, waits for idle, applies new inputs and restarts.
  task automatic applyStimulus(input int p, input int d1, input int d2, input int ph);
    int n = 0;
    en = 1'b0;
    @(negedge clk);
    while (active !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle wait", {1'b0, active}, 2'b00);
    period = 16'(p);
    duty1  = 16'(d1);
    duty2  = 16'(d2);
    phase  = 16'(ph);
    computeModel(p, d1, d2, ph);
    en = 1'b1;
    waitSync($sformatf("start P=%0d D1=%0d D2=%0d PHI=%0d", p, d1, d2, ph));
  endtask

  initial begin
    rst    = 1'b1;
    en     = 1'b0;
    period = '0;
    duty1  = '0;
    duty2  = '0;
    phase  = '0;
    repeat (2) @(negedge clk);
    checkIdle("in reset");
    rst = 1'b0;
    @(negedge clk);
    checkIdle("after reset");

    // Square wave, with start-up latency checked explicitly.
    period = 16'd8;
    duty1  = 16'd4;
    duty2  = 16'd4;
    phase  = 16'd0;
    computeModel(8, 4, 4, 0);
    en = 1'b1;
    @(negedge clk);
    checkIdle("first edge");
    @(negedge clk);
    checkCycle("square start", 0);
    checkPeriods("square", 2, -1, 0);

    // Asynchronous reset in the middle of a run.
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checkIdle("async reset");
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkIdle("idle after release");

    applyStimulus(8, 4, 4, 2);
    checkPeriods("phase", 2, -1, 0);

    applyStimulus(8, 2, 4, 0);
    checkPeriods("midupdate", 2, 3, 4);

    // Drain: en dropped at cnt 5, pulsed during the drain.
    applyStimulus(8, 4, 4, 2);
    checkPeriods("predrain", 1, -1, 0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checkCycle("drain", c);
      if (c == 4) en = 1'b0;
      if (c == 5) en = 1'b1;
      if (c == 6) en = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkIdle($sformatf("after drain %0d", i));
    end

    applyStimulus(9, 9, 4, 10);
    checkPeriods("clamp", 2, -1, 0);

    applyStimulus(4, 0, 2, 1);
    checkPeriods("d0 dhalf", 1, -1, 0);
    applyStimulus(6, 3, 0, 11);
    checkPeriods("phi wrap", 1, -1, 0);
    applyStimulus(2, 5, 5, 9);
    checkPeriods("min period", 1, -1, 0);

    for (int i = 0; i < 10; i++) begin
      int p, d1, d2, ph;
      p  = int'($urandom_range(0, 24));
      d1 = int'($urandom_range(0, p + 2));
      d2 = int'($urandom_range(0, p + 2));
      ph = int'($urandom_range(0, 2 * p + 4));
      applyStimulus(p, d1, d2, ph);
      checkPeriods($sformatf("rand%0d", i), 2, -1, 0);
    end

    en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
